// File: rtl/vscale_md_issue.sv
// Requester-side controller for the mul/div unit: decodes RV32M funct3, issues one
// request at a time, answers divide special cases locally and drains killed responses.
module vscale_md_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  input  logic [4:0]  cmd_rd,
  input  logic        kill,
  output logic        md_req_valid,
  input  logic        md_req_ready,
  output logic        md_req_op,
  output logic        md_req_out_sel,
  output logic        md_req_in_1_signed,
  output logic        md_req_in_2_signed,
  output logic [31:0] md_req_in_1,
  output logic [31:0] md_req_in_2,
  input  logic        md_resp_valid,
  input  logic [31:0] md_resp_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic MD_OP_MUL  = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;
  localparam logic MD_OUT_LO  = 1'b0;
  localparam logic MD_OUT_HI  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state, state_next;

  logic        dec_op, dec_out_sel, dec_s1, dec_s2;
  logic        div_by_zero, div_ovf, special;
  logic [31:0] special_result;
  logic        accept, capture_resp;

  always_comb begin
    dec_op      = MD_OP_MUL;
    dec_out_sel = MD_OUT_LO;
    dec_s1      = 1'b1;
    dec_s2      = 1'b1;
    case (cmd_funct3)
      3'd0: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_LO; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      3'd1: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      3'd2: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b0; end
      3'd3: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI; dec_s1 = 1'b0; dec_s2 = 1'b0; end
      3'd4: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_LO; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      3'd5: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_LO; dec_s1 = 1'b0; dec_s2 = 1'b0; end
      3'd6: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_HI; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      default: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_HI; dec_s1 = 1'b0; dec_s2 = 1'b0; end
    endcase
  end

  // Divide cases whose RISC-V result is fixed, so the unit never sees them.
  always_comb begin
    div_by_zero    = (dec_op == MD_OP_DIV) && (cmd_rs2 == 32'd0);
    div_ovf        = (dec_op == MD_OP_DIV) && dec_s1 &&
                     (cmd_rs1 == 32'h8000_0000) && (cmd_rs2 == 32'hFFFF_FFFF);
    special        = div_by_zero || div_ovf;
    special_result = 32'd0;
    if (div_by_zero)
      special_result = (dec_out_sel == MD_OUT_HI) ? cmd_rs1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_result = (dec_out_sel == MD_OUT_HI) ? 32'd0 : 32'h8000_0000;
  end

  // Handshakes: a transfer on cmd, md_req and wb happens on the rising edge where
  // both valid and ready are high; md_resp_valid is a pulse that cannot be stalled.
  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    accept       = 1'b0;
    capture_resp = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~kill & ~reset;
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = special ? WB : ISSUE;
        end
      end
      ISSUE: begin
        if (kill)              state_next = md_req_ready ? DRAIN : IDLE;
        else if (md_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (md_resp_valid) begin
          capture_resp = ~kill;
          state_next   = kill ? IDLE : WB;
        end else if (kill) begin
          state_next = DRAIN;
        end
      end
      WB: begin
        if (kill || wb_ready) state_next = IDLE;
      end
      DRAIN: begin
        if (md_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      md_req_op          <= 1'b0;
      md_req_out_sel     <= 1'b0;
      md_req_in_1_signed <= 1'b0;
      md_req_in_2_signed <= 1'b0;
      md_req_in_1        <= 32'd0;
      md_req_in_2        <= 32'd0;
      wb_rd              <= 5'd0;
      wb_data            <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        md_req_op          <= dec_op;
        md_req_out_sel     <= dec_out_sel;
        md_req_in_1_signed <= dec_s1;
        md_req_in_2_signed <= dec_s2;
        md_req_in_1        <= cmd_rs1;
        md_req_in_2        <= cmd_rs2;
        wb_rd              <= cmd_rd;
        if (special) wb_data <= special_result;
      end
      if (capture_resp) wb_data <= md_resp_result;
    end
  end

  assign md_req_valid = (state == ISSUE);
  assign wb_valid     = (state == WB);
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_vscale_md_issue.sv
// Directed bench for vscale_md_issue with a variable-latency mul/div responder and
// a writeback scoreboard fed from an RV32M reference function.
module tb_vscale_md_issue;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_rs1, cmd_rs2;
  logic [4:0]  cmd_rd;
  logic        kill;
  logic        md_req_valid, md_req_ready;
  logic        md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed;
  logic [31:0] md_req_in_1, md_req_in_2;
  logic        md_resp_valid;
  logic [31:0] md_resp_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ISSUE = 3'd1, ST_WAIT = 3'd2, ST_DRAIN = 3'd4;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  int   unit_lat   = 5;
  logic unit_stall = 1'b0;
  logic u_busy;
  int   u_cnt;
  logic [31:0] u_res;

  vscale_md_issue dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .kill(kill),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_op(md_req_op),
    .md_req_out_sel(md_req_out_sel), .md_req_in_1_signed(md_req_in_1_signed),
    .md_req_in_2_signed(md_req_in_2_signed), .md_req_in_1(md_req_in_1),
    .md_req_in_2(md_req_in_2), .md_resp_valid(md_resp_valid),
    .md_resp_result(md_resp_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference models ----------------
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    sa = a; sb = b;
    ea = {32'd0, a}; eb = {32'd0, b};
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) ea = {{32{a[31]}}, a};
    if (f3 == 3'd0 || f3 == 3'd1) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return sa / sb;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] unit_compute(input logic op, input logic sel, input logic s1,
                                               input logic s2, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    sa = a; sb = b;
    if (!op) return sel ? p[63:32] : p[31:0];
    if (s1)  return sel ? sa % sb : sa / sb;
    return sel ? a % b : a / b;
  endfunction

  // Mul/div responder: accepts when idle, answers after unit_lat cycles.
  always @(posedge clk) begin
    if (reset) begin
      u_busy         <= 1'b0;
      u_cnt          <= 0;
      u_res          <= 32'd0;
      md_req_ready   <= 1'b1;
      md_resp_valid  <= 1'b0;
      md_resp_result <= 32'd0;
    end else begin
      md_resp_valid <= 1'b0;
      if (u_busy) begin
        if (u_cnt <= 1) begin
          md_resp_valid  <= 1'b1;
          md_resp_result <= u_res;
          u_busy         <= 1'b0;
          md_req_ready   <= ~unit_stall;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end else if (md_req_valid && md_req_ready) begin
        u_busy       <= 1'b1;
        u_cnt        <= unit_lat;
        u_res        <= unit_compute(md_req_op, md_req_out_sel, md_req_in_1_signed,
                                     md_req_in_2_signed, md_req_in_1, md_req_in_2);
        md_req_ready <= 1'b0;
      end else begin
        md_req_ready <= ~unit_stall;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each completed writeback handshake pops one expected {rd, data}.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_wb_data", wb_data, e[31:0]);
        check("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command; returns in the cycle after acceptance.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit push);
    int n;
    cmd_valid = 1'b1; cmd_funct3 = f3; cmd_rs1 = a; cmd_rs2 = b; cmd_rd = rd;
    #1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    if (push) exp_q.push_back({rd, rv32m(f3, a, b)});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (!wb_valid && n < 100) begin tick(); n++; end
    check("wb_arrives", {31'd0, wb_valid}, 32'd1);
  endtask

  // Waits for IDLE and confirms no writeback appeared meanwhile.
  task automatic wait_idle_no_wb(input string tag);
    int n, saw;
    n = 0; saw = 0;
    while (dbg_state != ST_IDLE && n < 100) begin
      if (wb_valid) saw++;
      tick(); n++;
    end
    repeat (3) begin if (wb_valid) saw++; tick(); end
    check({tag, "_no_wb"}, saw, 0);
    check({tag, "_idle"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    reset = 1'b1; cmd_valid = 1'b0; cmd_funct3 = 3'd0; cmd_rs1 = 32'd0; cmd_rs2 = 32'd0;
    cmd_rd = 5'd0; kill = 1'b0; wb_ready = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_req_valid", {31'd0, md_req_valid}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // MULH -2 * 3
    unit_lat = 5;
    send(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd5, 1);
    check("mulh_req_valid", {31'd0, md_req_valid}, 32'd1);
    check("mulh_req_fields", {28'd0, md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed},
          32'b0111);
    check("mulh_req_in_1", md_req_in_1, 32'hFFFF_FFFE);
    check("mulh_req_in_2", md_req_in_2, 32'd3);
    wait_wb();
    check("mulh_wb_data", wb_data, 32'hFFFF_FFFF);
    check("mulh_wb_rd", {27'd0, wb_rd}, 32'd5);
    tick();
    check("mulh_busy_low", {31'd0, busy}, 32'd0);

    // DIVU 100 / 7 with writeback back-pressure
    unit_lat = 17; wb_ready = 1'b0;
    send(3'd5, 32'd100, 32'd7, 5'd9, 1);
    wait_wb();
    for (int i = 0; i < 3; i++) begin
      check("divu_hold_valid", {31'd0, wb_valid}, 32'd1);
      check("divu_hold_data", wb_data, 32'd14);
      check("divu_hold_rd", {27'd0, wb_rd}, 32'd9);
      if (i < 2) tick();
    end
    wb_ready = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_funct3 = 3'd6; cmd_rs1 = 32'h1234; cmd_rs2 = 32'd0;
    #1;
    check("throughput_ready", {31'd0, cmd_ready}, 32'd1);

    // Special cases answered locally at T+1
    send(3'd6, 32'h1234, 32'd0, 5'd1, 1);
    check("rem0_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("rem0_no_req", {31'd0, md_req_valid}, 32'd0);
    check("rem0_data", wb_data, 32'h1234);
    tick();
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1);
    check("divovf_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("divovf_no_req", {31'd0, md_req_valid}, 32'd0);
    check("divovf_data", wb_data, 32'h8000_0000);
    tick();
    send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1);
    check("removf_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("removf_no_req", {31'd0, md_req_valid}, 32'd0);
    check("removf_data", wb_data, 32'd0);
    tick();
    send(3'd4, 32'd77, 32'd0, 5'd4, 1);
    check("div0_data", wb_data, 32'hFFFF_FFFF);
    tick();
    // Unsigned ops with the same operands are not special
    unit_lat = 3;
    send(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1);
    check("remu_goes_to_unit", {31'd0, md_req_valid}, 32'd1);
    wait_wb();
    tick();

    // Kill in WAIT, cycle 2 of 17
    unit_lat = 17;
    send(3'd4, 32'd1000, 32'd3, 5'd7, 0);
    tick();
    tick();
    check("kwait_in_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    kill = 1'b1; tick(); kill = 1'b0;
    check("kwait_drain", {29'd0, dbg_state}, {29'd0, ST_DRAIN});
    wait_idle_no_wb("kwait");
    unit_lat = 5;
    send(3'd0, 32'd6, 32'd7, 5'd8, 1);
    wait_wb();
    check("mul42", wb_data, 32'd42);
    tick();

    // Kill coinciding with the request handshake
    unit_lat = 6;
    send(3'd0, 32'd11, 32'd13, 5'd10, 0);
    check("kiss_req_ready", {31'd0, md_req_ready}, 32'd1);
    kill = 1'b1; tick(); kill = 1'b0;
    check("kiss_drain", {29'd0, dbg_state}, {29'd0, ST_DRAIN});
    wait_idle_no_wb("kiss");

    // Kill in ISSUE while the unit is not ready
    unit_stall = 1'b1; tick();
    send(3'd0, 32'd2, 32'd3, 5'd11, 0);
    check("kstall_issue", {29'd0, dbg_state}, {29'd0, ST_ISSUE});
    kill = 1'b1; tick(); kill = 1'b0;
    check("kstall_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    unit_stall = 1'b0;
    wait_idle_no_wb("kstall");

    // Kill coinciding with the response pulse
    unit_lat = 4;
    send(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12, 0);
    for (int i = 0; i < 50 && !md_resp_valid; i++) tick();
    check("kresp_pulse", {31'd0, md_resp_valid}, 32'd1);
    kill = 1'b1; tick(); kill = 1'b0;
    check("kresp_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("kresp_no_wb", {31'd0, wb_valid}, 32'd0);
    wait_idle_no_wb("kresp");

    // Kill while holding a writeback
    wb_ready = 1'b0;
    send(3'd5, 32'd5, 32'd0, 5'd13, 0);
    check("kwb_valid", {31'd0, wb_valid}, 32'd1);
    kill = 1'b1; tick(); kill = 1'b0;
    check("kwb_dropped", {31'd0, wb_valid}, 32'd0);
    wb_ready = 1'b1;

    // Random operations with random unit latency
    for (int i = 0; i < 10; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      unit_lat = $urandom_range(1, 20);
      send(rf3, ra, rb, 5'($urandom_range(0, 31)), 1);
      wait_wb();
      tick();
    end

    // Reset while waiting on the unit
    unit_lat = 17;
    send(3'd4, 32'd500, 32'd5, 5'd21, 0);
    tick(); tick();
    check("rwait_in_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    reset = 1'b1; tick();
    check("rwait_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rwait_req_valid", {31'd0, md_req_valid}, 32'd0);
    check("rwait_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rwait_busy", {31'd0, busy}, 32'd0);
    check("rwait_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rwait_wb_data", wb_data, 32'd0);
    check("rwait_req_in", md_req_in_1 | md_req_in_2, 32'd0);
    check("rwait_req_flags", {28'd0, md_req_op, md_req_out_sel, md_req_in_1_signed, md_req_in_2_signed},
          32'd0);
    reset = 1'b0; tick();
    check("rwait_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    wait_idle_no_wb("rwait");

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_md_issue.md
# vscale_md_issue

Requester-side controller for the multiply/divide unit: accepts decoded RV32M operations from the pipeline, maps `funct3` onto the unit's request fields, drives the `req_valid`/`req_ready` handshake, captures the single-cycle `resp_valid` pulse, and presents the result on a back-pressured writeback port. Divide-by-zero and signed-overflow divides are answered locally without issuing to the unit. A pipeline `kill` abandons the operation, draining any in-flight unit response so that stale results never reach writeback.

## Interface
Parameters: none.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; shared with the mul/div unit
- `cmd_valid`  in  1  operation offered by the pipeline
- `cmd_ready`  out  1  operation accepted this cycle when high with `cmd_valid`
- `cmd_funct3`  in  3  RV32M funct3 (0 MUL … 7 REMU)
- `cmd_rs1`, `cmd_rs2`  in  32  operands
- `cmd_rd`  in  5  destination register
- `kill`  in  1  abandon current operation
- `md_req_valid`  out  1  request to unit
- `md_req_ready`  in  1  unit idle
- `md_req_op`  out  1  0 = MUL, 1 = DIV (`MD_OP_*`)
- `md_req_out_sel`  out  1  0 = LO (low product / quotient), 1 = HI (high product / remainder) (`MD_OUT_*`)
- `md_req_in_1_signed`, `md_req_in_2_signed`  out  1  operand signedness
- `md_req_in_1`, `md_req_in_2`  out  32  operands
- `md_resp_valid`  in  1  one-cycle result pulse; no back-pressure
- `md_resp_result`  in  32  result, valid only with `md_resp_valid`
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  writeback consumed
- `wb_rd`  out  5  destination
- `wb_data`  out  32  result
- `busy`  out  1  state ≠ IDLE

## Operation
- Decode (registered at accept): funct3 → {op, out_sel, s1, s2}:
  - 0 → {0,0,1,1}
  - 1 → {0,1,1,1}
  - 2 → {0,1,1,0}
  - 3 → {0,1,0,0}
  - 4 → {1,0,1,1}
  - 5 → {1,0,0,0}
  - 6 → {1,1,1,1}
  - 7 → {1,1,0,0}
- Special cases, evaluated only when op = DIV:
  - rs2 = 0: quotient result is 0xFFFFFFFF; remainder result is rs1.
  - Signed (funct3 4/6) with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient result is 0x80000000; remainder result is 0.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
  - IDLE: `cmd_ready` = ~kill. On accept, go to WB with the local result if a special case applies, otherwise to ISSUE.
  - ISSUE: `md_req_valid` = 1; request fields come from holding registers and are stable. When `md_req_ready` is high, go to WAIT.
  - WAIT: on `md_resp_valid`, capture `md_resp_result` into `wb_data` and go to WB.
  - WB: `wb_valid` = 1. On `wb_ready`, go to IDLE.
  - DRAIN: on `md_resp_valid`, discard the result and go to IDLE.
- Kill:
  - ISSUE with `md_req_ready` low → IDLE.
  - ISSUE with `md_req_ready` high (request already accepted) → DRAIN.
  - WAIT → DRAIN.
  - WAIT with `md_resp_valid` in the same cycle → IDLE; the result is discarded.
  - WB → IDLE; `wb_valid` drops the next cycle.
  - IDLE or DRAIN: no effect.
- The block issues at most one outstanding request. It never asserts `md_req_valid` while in WAIT or DRAIN.
- `md_resp_valid` in IDLE, ISSUE or WB is ignored.
- Result width: 32 bits. No arithmetic is performed beyond the special-case comparisons.

## Timing
- Reset values:
  - Outputs: `cmd_ready` = 0 during reset; `md_req_valid`, `wb_valid` and `busy` = 0.
  - Output data fields (`md_req_*` data, `wb_rd`, `wb_data`): 0.
  - State: IDLE.
- Reset mid-operation: return to IDLE immediately. No drain is required, because the unit is reset by the same signal.
- Cycle timing, with accept at cycle T:
  - Normal path: `md_req_valid` is high in cycle T+1.
  - Special-case path: `wb_valid` is high in cycle T+1.
- The unit's latency is not fixed in this block. Any delay of at least 1 cycle between the unit accepting the request and `md_resp_valid` must work. The unit's nominal latency is 5 cycles for MUL and about 17 cycles for DIV.
- The cycle after `md_resp_valid`, `wb_valid` = 1.
- Throughput: a new `cmd` can be accepted in the cycle after the `wb_valid`/`wb_ready` handshake.
- `wb_data` and `wb_rd` hold stable while `wb_valid` is high and `wb_ready` is low.

## Test plan
- MULH, rs1 = 0xFFFFFFFE, rs2 = 3, unit model latency 5 → `md_req_op` = 0, `out_sel` = 1, both signed = 1; `wb_data` = 0xFFFFFFFF, `wb_rd` echoed; `busy` returns low after `wb_ready`.
- DIVU, rs1 = 100, rs2 = 7, latency 17, `wb_ready` held low 3 cycles → `wb_data` = 14 stays stable while `wb_valid` is high; next command accepted one cycle after the handshake.
- Special cases (no `md_req_valid` in any of them):
  - REM with rs2 = 0, rs1 = 0x1234 → `wb_valid` at T+1, `wb_data` = 0x1234.
  - DIV with 0x80000000 / 0xFFFFFFFF → `wb_data` = 0x80000000.
  - REM with the same operands → `wb_data` = 0.
- Kill in WAIT at cycle 2 of 17 → state DRAIN. The late `md_resp_valid` produces no `wb_valid`. The next command MUL 6 × 7 gives `wb_data` = 42.
- Kill in the same cycle as the ISSUE handshake → DRAIN, no writeback. Kill in the same cycle as `md_resp_valid` → IDLE, no writeback.
- Reset asserted during WAIT → all outputs 0, `cmd_ready` high the cycle after reset drops.
